uart_transceiver: RTL and testbench
===================================

Name: uart_transceiver

Overview:
Parametrised full-duplex UART endpoint that replaces the fixed 8-bit transmitter/receiver pair.
- TX: valid/ready byte interface, generates start, data (LSB first), optional parity and 1 or 2 stop bits at a programmable bit period.
- RX: independent. Synchronises and mid-bit samples the serial line, then reports each word with parity and framing status.
- Instantiated at chip top; serial_out may be looped to serial_in for self-test.

Parameters:
DATA_BITS, 8, payload width per frame; legal 5..9.
CLKS_PER_BIT, 16, clk cycles per serial bit; legal >= 4.
PARITY_EN, 1, 1 = parity bit present after data.
PARITY_ODD, 0, 0 = even parity, 1 = odd; ignored when PARITY_EN = 0.
STOP_BITS, 1, stop bits transmitted; legal 1 or 2.

Ports:
clk  input  1  single clock; all logic on rising edge.
prst  input  1  synchronous, active-low reset.
tx_data  input  DATA_BITS  word to send; sampled on handshake.
tx_valid  input  1  tx_data valid.
tx_ready  output  1  high when TX can accept a word.
serial_out  output  1  TX line; idle high.
serial_in  input  1  RX line; asynchronous to clk.
rx_data  output  DATA_BITS  last received word; held until next rx_valid.
rx_valid  output  1  one-cycle pulse per received frame.
rx_parity_err  output  1  parity mismatch on last frame; updated with rx_valid.
rx_frame_err  output  1  first stop bit sampled low on last frame; updated with rx_valid.

Behaviour:
- Reset (prst = 0 at a clk edge):
  - Both FSMs go to IDLE and all counters clear.
  - serial_out = 1, tx_ready = 1, rx_valid = 0, rx_data = 0, both error flags = 0.
  - RX synchroniser flops reset to 1.
  - Reset mid-frame aborts the frame immediately. No partial rx_valid is issued.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - tx_ready = 1 only in IDLE.
  - Handshake occurs on the edge where tx_valid & tx_ready are both high; tx_data is latched into a shift register.
  - The next cycle enters START with serial_out = 0 and tx_ready = 0.
  - Every bit is held exactly CLKS_PER_BIT cycles.
  - DATA shifts LSB first and sends DATA_BITS bits.
  - PARITY is skipped when PARITY_EN = 0. The parity bit = XOR of data, inverted when PARITY_ODD = 1.
  - STOP drives 1 for STOP_BITS × CLKS_PER_BIT cycles, then returns to IDLE.
  - With tx_valid held high, consecutive frames are separated by exactly one IDLE cycle, with serial_out = 1 during that cycle.
  - tx_data changes while busy have no effect.
- RX path:
  - serial_in passes through a 2-flop synchroniser. All decisions use the synchronised bit rx_s.
  - IDLE → START when rx_s = 0.
  - START waits CLKS_PER_BIT/2 cycles (integer division) and re-samples.
    - rx_s = 1: false start; return to IDLE with no output.
    - rx_s = 0: enter DATA.
  - DATA samples every CLKS_PER_BIT cycles thereafter, at bit centres, shifting LSB first. Then PARITY (if enabled), then STOP.
  - At the first stop-bit sample, in the same cycle:
    - rx_valid = 1.
    - rx_data = assembled word.
    - rx_parity_err = (received parity ≠ computed parity); forced 0 when PARITY_EN = 0.
    - rx_frame_err = ~rx_s.
  - After that sample:
    - Stop bit = 1: return to IDLE immediately. A second stop bit is not checked.
    - Stop bit = 0 (framing error / break): enter WAIT_HIGH and stay until rx_s = 1, then IDLE.
- Bit-timer counters are sized to clog2(CLKS_PER_BIT); the bit index is sized to clog2(DATA_BITS + 1).
- TX and RX are fully independent. Simultaneous TX and RX activity, including loopback, needs no arbitration.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t and rx_state_t enums (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH).
  - Function parity_calc(data, odd).
  - Frame-length constant derivation: 1 + DATA_BITS + PARITY_EN + STOP_BITS.
- One natural sub-module, uart_bit_timer. It is a down-counter with load value and terminal-count pulse, instantiated once in TX and once in RX.

Test Plan:
- Reset: hold prst = 0 for 3 cycles mid-idle → serial_out = 1, tx_ready = 1, rx_valid = 0, rx_data = 0x00, both errors = 0.
- Loopback (defaults), send 0xA5 → serial_out checked against expected pattern:
  - 0 for 16 cycles, then data bits 1,0,1,0,0,1,0,1, then parity 0, then stop 1.
  - rx_valid pulses once with rx_data = 0xA5, errors 0.
  - tx_ready returns 1 at cycle 177 after handshake.
- Back-to-back: send 0x00 then 0xFF with tx_valid held high →
  - tx_ready high for exactly 1 cycle between frames.
  - Two rx_valid pulses with 0x00 and 0xFF, 177 cycles apart.
- Parity error: drive serial_in with frame 0x01 and parity bit 0 → rx_valid, rx_data = 0x01, rx_parity_err = 1, rx_frame_err = 0.
- Break/frame error: drive line low for 20 bit times → rx_valid with rx_data = 0x00, rx_frame_err = 1. No further rx_valid until the line is high, then frame 0x3C is received correctly.
- Glitch and mid-frame reset:
  - serial_in low for 4 cycles → no rx_valid.
  - prst = 0 during TX DATA → serial_out = 1 on the next cycle, tx_ready = 1 after release, and the far-end receiver emits no valid word for the aborted frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transceiver: FSM state encodings,
// the parity function and frame-length derivation.
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Narrower words are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic int frame_bits(input int data_bits, input int parity_en, input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: load sets the count, tc is high once it has run out.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 16,
  localparam int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          prst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!prst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART endpoint: valid/ready TX serialiser and an independent
// mid-bit-sampling RX deserialiser with parity and framing status.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 prst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 serial_out,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int CW         = $clog2(CLKS_PER_BIT);
  localparam int BW         = $clog2(DATA_BITS + 1);
  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY_EN, STOP_BITS);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS || CLKS_PER_BIT < 4 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FRAME_BITS > 13) begin : g_param_check
    $error("uart_transceiver: illegal parameter combination");
  end

  tx_state_t            tx_state;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_par;
  logic [BW-1:0]        tx_idx;
  logic                 tx_load, tx_tc, tx_shift;

  // In IDLE the timer is armed by the handshake; otherwise it re-arms every bit.
  assign tx_load  = tx_ready ? tx_valid : tx_tc;
  assign tx_shift = tx_tc && ((tx_state == TX_START) ||
                              (tx_state == TX_DATA && tx_idx != BW'(DATA_BITS)));

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk      (clk),
    .prst     (prst),
    .load     (tx_load),
    .load_val (BIT_LOAD),
    .tc       (tx_tc)
  );

  always_ff @(posedge clk) begin
    if (tx_valid && tx_ready) begin
      tx_shreg <= tx_data;
      tx_par   <= parity_calc(MAX_DATA_BITS'(tx_data), PARITY_ODD != 0);
    end else if (tx_shift) begin
      tx_shreg <= tx_shreg >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!prst) begin
      tx_state   <= TX_IDLE;
      tx_ready   <= 1'b1;
      serial_out <= 1'b1;
      tx_idx     <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: if (tx_valid) begin
          tx_state   <= TX_START;
          tx_ready   <= 1'b0;
          serial_out <= 1'b0;
          tx_idx     <= '0;
        end
        TX_START: if (tx_tc) begin
          tx_state   <= TX_DATA;
          serial_out <= tx_shreg[0];
          tx_idx     <= BW'(1);
        end
        TX_DATA: if (tx_tc) begin
          if (tx_idx != BW'(DATA_BITS)) begin
            serial_out <= tx_shreg[0];
            tx_idx     <= tx_idx + 1'b1;
          end else if (PARITY_EN != 0) begin
            tx_state   <= TX_PARITY;
            serial_out <= tx_par;
          end else begin
            tx_state   <= TX_STOP;
            serial_out <= 1'b1;
            tx_idx     <= BW'(1);
          end
        end
        TX_PARITY: if (tx_tc) begin
          tx_state   <= TX_STOP;
          serial_out <= 1'b1;
          tx_idx     <= BW'(1);
        end
        TX_STOP: if (tx_tc) begin
          if (tx_idx == BW'(STOP_BITS)) begin
            tx_state <= TX_IDLE;
            tx_ready <= 1'b1;
          end else begin
            tx_idx <= tx_idx + 1'b1;
          end
        end
        default: begin
          tx_state   <= TX_IDLE;
          tx_ready   <= 1'b1;
          serial_out <= 1'b1;
        end
      endcase
    end
  end

  rx_state_t            rx_state;
  logic                 rx_meta, rx_s;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_par_bit;
  logic [BW-1:0]        rx_idx;
  logic                 rx_load, rx_tc;
  logic [CW-1:0]        rx_load_val;

  // A falling edge arms a half-bit wait so later samples land at bit centres.
  always_comb begin
    rx_load     = 1'b0;
    rx_load_val = BIT_LOAD;
    case (rx_state)
      RX_IDLE: begin
        rx_load     = !rx_s;
        rx_load_val = HALF_LOAD;
      end
      RX_START, RX_DATA, RX_PARITY: rx_load = rx_tc;
      default: rx_load = 1'b0;
    endcase
  end

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk      (clk),
    .prst     (prst),
    .load     (rx_load),
    .load_val (rx_load_val),
    .tc       (rx_tc)
  );

  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && rx_tc) begin
      rx_shreg <= {rx_s, rx_shreg[DATA_BITS-1:1]};
    end
    if (rx_state == RX_PARITY && rx_tc) begin
      rx_par_bit <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!prst) begin
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_idx        <= '0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_meta  <= serial_in;
      rx_s     <= rx_meta;
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: if (!rx_s) rx_state <= RX_START;
        RX_START: if (rx_tc) begin
          rx_state <= rx_s ? RX_IDLE : RX_DATA;
          rx_idx   <= '0;
        end
        RX_DATA: if (rx_tc) begin
          rx_idx <= rx_idx + 1'b1;
          if (rx_idx == BW'(DATA_BITS - 1)) begin
            rx_state <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: if (rx_tc) rx_state <= RX_STOP;
        RX_STOP: if (rx_tc) begin
          rx_valid      <= 1'b1;
          rx_data       <= rx_shreg;
          rx_parity_err <= (PARITY_EN != 0) &&
                           (rx_par_bit != parity_calc(MAX_DATA_BITS'(rx_shreg), PARITY_ODD != 0));
          rx_frame_err  <= !rx_s;
          rx_state      <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
        end
        RX_WAIT_HIGH: if (rx_s) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Scoreboard bench for uart_transceiver: loopback and directly driven serial frames
// checked against a bit-level model of the UART frame format.
module tb_uart_transceiver;

  localparam int DATA_BITS    = 8;
  localparam int CLKS_PER_BIT = 16;
  localparam int PARITY_EN    = 1;
  localparam int PARITY_ODD   = 0;
  localparam int STOP_BITS    = 1;
  localparam int FRAME_LEN    = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
  localparam int FRAME_CLKS   = FRAME_LEN * CLKS_PER_BIT;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rx_word_t;

  logic       clk = 1'b0;
  logic       prst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, serial_out, serial_in;
  logic [7:0] rx_data;
  logic       rx_valid, rx_parity_err, rx_frame_err;
  logic       loop_en = 1'b1;
  logic       line_drv = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rx_count = 0;
  int last_rx_cyc = 0;
  int prev_rx_cyc = 0;
  rx_word_t exp_q[$];

  assign serial_in = loop_en ? serial_out : line_drv;

  always #5 clk = ~clk;

  uart_transceiver #(
    .DATA_BITS(DATA_BITS), .CLKS_PER_BIT(CLKS_PER_BIT), .PARITY_EN(PARITY_EN),
    .PARITY_ODD(PARITY_ODD), .STOP_BITS(STOP_BITS)
  ) dut (
    .clk(clk), .prst(prst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .serial_out(serial_out), .serial_in(serial_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  function automatic logic exp_par(input logic [7:0] d);
    return (($countones(d) % 2) != PARITY_ODD);
  endfunction

  // Reference frame: start 0, data LSB first, parity, stop bits at 1.
  function automatic logic frame_bit(input logic [7:0] d, input logic par, input logic stop, input int j);
    if (j == 0) return 1'b0;
    if (j <= DATA_BITS) return d[j-1];
    if (PARITY_EN != 0 && j == DATA_BITS + 1) return par;
    return stop;
  endfunction

  function automatic rx_word_t model_rx(input logic [7:0] d, input logic par, input logic stop);
    rx_word_t w;
    w.data = d;
    w.perr = (PARITY_EN != 0) && ((($countones(d) + int'(par)) % 2) != PARITY_ODD);
    w.ferr = !stop;
    return w;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    rx_word_t e;
    if (prst && rx_valid) begin
      rx_count++;
      prev_rx_cyc = last_rx_cyc;
      last_rx_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("rx_unexpected_word", {24'h0, rx_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", {24'h0, rx_data}, {24'h0, e.data});
        check("rx_parity_err", {31'h0, rx_parity_err}, {31'h0, e.perr});
        check("rx_frame_err", {31'h0, rx_frame_err}, {31'h0, e.ferr});
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("tx_ready_timeout", {31'h0, tx_ready}, 32'h1);
  endtask

  task automatic send_word(input logic [7:0] d, input bit check_line);
    bit ok;
    int mis;
    wait_ready(ok);
    if (ok) begin
      tx_data  = d;
      tx_valid = 1'b1;
      exp_q.push_back(model_rx(d, exp_par(d), 1'b1));
      mis = 0;
      for (int k = 0; k <= FRAME_CLKS; k++) begin
        @(negedge clk);
        if (k == 0) begin
          tx_valid = 1'b0;
          tx_data  = ~d;
        end
        if (k < FRAME_CLKS) begin
          if (serial_out !== frame_bit(d, exp_par(d), 1'b1, k / CLKS_PER_BIT)) mis++;
          if (tx_ready !== 1'b0) mis++;
        end
      end
      if (check_line) begin
        check("tx_line_mismatch_cycles", mis, 0);
        check("tx_ready_at_frame_end", {31'h0, tx_ready}, 32'h1);
        check("tx_line_idle_after_frame", {31'h0, serial_out}, 32'h1);
      end
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop);
    exp_q.push_back(model_rx(d, par, stop));
    for (int j = 0; j < FRAME_LEN; j++) begin
      line_drv = frame_bit(d, par, stop, j);
      repeat (CLKS_PER_BIT) @(negedge clk);
    end
    line_drv = 1'b1;
    repeat (2 * CLKS_PER_BIT) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit ok;
    int c0, hi;
    bit done;
    logic [7:0] d;
    logic p, s;

    repeat (3) @(negedge clk);
    check("reset_serial_out", {31'h0, serial_out}, 32'h1);
    check("reset_tx_ready", {31'h0, tx_ready}, 32'h1);
    check("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("reset_rx_data", {24'h0, rx_data}, 32'h0);
    check("reset_parity_err", {31'h0, rx_parity_err}, 32'h0);
    check("reset_frame_err", {31'h0, rx_frame_err}, 32'h0);
    prst = 1'b1;
    repeat (4) @(negedge clk);

    c0 = rx_count;
    send_word(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    check("loopback_a5_rx_count", rx_count - c0, 1);

    c0 = rx_count;
    wait_ready(ok);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    exp_q.push_back(model_rx(8'h00, exp_par(8'h00), 1'b1));
    @(negedge clk);
    tx_data = 8'hFF;
    exp_q.push_back(model_rx(8'hFF, exp_par(8'hFF), 1'b1));
    hi = 0;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (tx_ready) hi++;
      else if (hi > 0) done = 1'b1;
    end
    tx_valid = 1'b0;
    check("b2b_ready_gap_cycles", hi, 1);
    repeat (FRAME_CLKS + 40) @(negedge clk);
    check("b2b_rx_count", rx_count - c0, 2);
    check("b2b_rx_spacing", last_rx_cyc - prev_rx_cyc, FRAME_CLKS + 1);

    for (int i = 0; i < 4; i++) send_word(8'($urandom_range(0, 255)), 1'b1);
    repeat (20) @(negedge clk);

    loop_en = 1'b0;
    line_drv = 1'b1;
    repeat (CLKS_PER_BIT) @(negedge clk);
    c0 = rx_count;
    drive_frame(8'h01, 1'b0, 1'b1);
    check("parity_err_frame_count", rx_count - c0, 1);

    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      p = exp_par(d) ^ 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) != 0);
      drive_frame(d, p, s);
    end

    c0 = rx_count;
    exp_q.push_back(model_rx(8'h00, 1'b0, 1'b0));
    line_drv = 1'b0;
    repeat (20 * CLKS_PER_BIT) @(negedge clk);
    check("break_rx_count", rx_count - c0, 1);
    line_drv = 1'b1;
    repeat (2 * CLKS_PER_BIT) @(negedge clk);
    check("break_no_extra_rx", rx_count - c0, 1);
    drive_frame(8'h3C, exp_par(8'h3C), 1'b1);
    check("after_break_rx_count", rx_count - c0, 2);

    c0 = rx_count;
    line_drv = 1'b0;
    repeat (4) @(negedge clk);
    line_drv = 1'b1;
    repeat (3 * CLKS_PER_BIT) @(negedge clk);
    check("glitch_rx_count", rx_count - c0, 0);

    loop_en = 1'b1;
    c0 = rx_count;
    wait_ready(ok);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (3 * CLKS_PER_BIT) @(negedge clk);
    check("midframe_line_low", {31'h0, serial_out}, 32'h0);
    prst = 1'b0;
    @(negedge clk);
    check("midframe_reset_line_high", {31'h0, serial_out}, 32'h1);
    check("midframe_reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    repeat (2) @(negedge clk);
    prst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'h0, tx_ready}, 32'h1);
    check("rx_data_after_reset", {24'h0, rx_data}, 32'h0);
    repeat (FRAME_CLKS + 40) @(negedge clk);
    check("aborted_frame_no_rx", rx_count - c0, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
